// File: rtl/line_xfer_ctrl_if.sv
// Bundle of request, status, SRAM-side and SDRAM-side signals for line_xfer_ctrl.
// Names carry the controller's point of view: *_i are driven into the controller,
// *_o are driven by it.
//   start_i/op_i/blk_i/old_tag_i/new_tag_i : transfer request
//   busy_o/done_o/current_state_o          : status
//   sram_*                                 : local SRAM port (8-bit address {blk,off})
//   sdram_*                                : SDRAM port ({tag,blk,off} address, one strobe per byte)
interface line_xfer_ctrl_if #(
    parameter int unsigned TAG_W = 8
);
    localparam int unsigned SDRAM_AW = TAG_W + 8;

    logic                start_i;
    logic [1:0]          op_i;
    logic [2:0]          blk_i;
    logic [TAG_W-1:0]    old_tag_i;
    logic [TAG_W-1:0]    new_tag_i;
    logic                busy_o;
    logic                done_o;
    logic [2:0]          current_state_o;
    logic                sram_own_o;
    logic [7:0]          sram_addr_o;
    logic [7:0]          sram_din_o;
    logic [7:0]          sram_dout_i;
    logic                sram_wen_o;
    logic [SDRAM_AW-1:0] sdram_addr_o;
    logic                sdram_wr_rd_o;
    logic                sdram_mstrb_o;
    logic [7:0]          sdram_din_o;
    logic [7:0]          sdram_dout_i;

    // Requester / memory-model side
    modport master (
        output start_i, op_i, blk_i, old_tag_i, new_tag_i, sram_dout_i, sdram_dout_i,
        input  busy_o, done_o, current_state_o, sram_own_o, sram_addr_o, sram_din_o,
               sram_wen_o, sdram_addr_o, sdram_wr_rd_o, sdram_mstrb_o, sdram_din_o
    );

    // Controller side
    modport slave (
        input  start_i, op_i, blk_i, old_tag_i, new_tag_i, sram_dout_i, sdram_dout_i,
        output busy_o, done_o, current_state_o, sram_own_o, sram_addr_o, sram_din_o,
               sram_wen_o, sdram_addr_o, sdram_wr_rd_o, sdram_mstrb_o, sdram_din_o
    );
endinterface

// File: rtl/line_xfer_ctrl.sv
// Cache line transfer controller: writes a 32-byte SRAM block back to SDRAM
// and/or refills it from SDRAM, one byte at a time.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : line_xfer_ctrl_if slave (request, status, SRAM and SDRAM ports)
// RD_LAT (1..7) is the SDRAM strobe-to-data latency; TAG_W is the tag width.
module line_xfer_ctrl #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    line_xfer_ctrl_if.slave  bus
);
    localparam int unsigned OFF_W     = 5;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned ADDR_W    = TAG_W + IDX_W + OFF_W;
    localparam int unsigned CNT_W     = 3;
    // RF_WAIT lasts RD_LAT-1 cycles; the counter loads one less and exits at zero
    localparam int unsigned WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_SRAM = 3'd1,
        WB_STRB = 3'd2,
        RF_STRB = 3'd3,
        RF_WAIT = 3'd4,
        RF_WR   = 3'd5,
        DONE    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   blk_q, blk_d;
    logic [TAG_W-1:0]   old_tag_q, old_tag_d;
    logic [TAG_W-1:0]   new_tag_q, new_tag_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mstrb_q, mstrb_d;
    logic               wr_rd_q, wr_rd_d;
    logic               wen_q, wen_d;
    logic [7:0]         sram_addr_q, sram_addr_d;
    logic [ADDR_W-1:0]  sdram_addr_q, sdram_addr_d;

    // Next state, request latching and output decode from the next state so
    // control/address outputs leave registers aligned with the state.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        op_d         = op_q;
        blk_d        = blk_q;
        old_tag_d    = old_tag_q;
        new_tag_d    = new_tag_q;
        wait_d       = wait_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    op_d      = bus.op_i;
                    blk_d     = bus.blk_i;
                    old_tag_d = bus.old_tag_i;
                    new_tag_d = bus.new_tag_i;
                    off_d     = '0;
                    if (bus.op_i[0])      state_d = WB_SRAM;
                    else if (bus.op_i[1]) state_d = RF_STRB;
                    else                  state_d = DONE;
                end
            end
            WB_SRAM: state_d = WB_STRB;
            WB_STRB: begin
                off_d = off_q + OFF_W'(1);
                if (off_q == '1) state_d = op_q[1] ? RF_STRB : DONE;
                else             state_d = WB_SRAM;
            end
            RF_STRB: begin
                if (RD_LAT > 1) begin
                    state_d = RF_WAIT;
                    wait_d  = CNT_W'(WAIT_INIT);
                end else begin
                    state_d = RF_WR;
                end
            end
            RF_WAIT: begin
                if (wait_q == '0) state_d = RF_WR;
                else              wait_d  = wait_q - CNT_W'(1);
            end
            RF_WR: begin
                off_d   = off_q + OFF_W'(1);
                state_d = (off_q == '1) ? DONE : RF_STRB;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        mstrb_d      = 1'b0;
        wr_rd_d      = 1'b0;
        wen_d        = 1'b0;
        sram_addr_d  = '0;
        sdram_addr_d = '0;

        case (state_d)
            WB_SRAM: sram_addr_d = {blk_d, off_d};
            WB_STRB: begin
                mstrb_d      = 1'b1;
                wr_rd_d      = 1'b1;
                sdram_addr_d = {old_tag_d, blk_d, off_d};
            end
            RF_STRB: begin
                mstrb_d      = 1'b1;
                sdram_addr_d = {new_tag_d, blk_d, off_d};
            end
            RF_WR: begin
                wen_d       = 1'b1;
                sram_addr_d = {blk_d, off_d};
            end
            default: ;
        endcase
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= '0;
            op_q         <= '0;
            blk_q        <= '0;
            old_tag_q    <= '0;
            new_tag_q    <= '0;
            wait_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mstrb_q      <= 1'b0;
            wr_rd_q      <= 1'b0;
            wen_q        <= 1'b0;
            sram_addr_q  <= '0;
            sdram_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            op_q         <= op_d;
            blk_q        <= blk_d;
            old_tag_q    <= old_tag_d;
            new_tag_q    <= new_tag_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mstrb_q      <= mstrb_d;
            wr_rd_q      <= wr_rd_d;
            wen_q        <= wen_d;
            sram_addr_q  <= sram_addr_d;
            sdram_addr_q <= sdram_addr_d;
        end
    end

    assign bus.busy_o          = busy_q;
    assign bus.sram_own_o      = busy_q;
    assign bus.done_o          = done_q;
    assign bus.current_state_o = state_q;
    assign bus.sdram_mstrb_o   = mstrb_q;
    assign bus.sdram_wr_rd_o   = wr_rd_q;
    assign bus.sdram_addr_o    = sdram_addr_q;
    assign bus.sram_wen_o      = wen_q;
    assign bus.sram_addr_o     = sram_addr_q;

    // Byte data flows straight through in the cycle it is valid on the source port
    assign bus.sdram_din_o = (state_q == WB_STRB) ? bus.sram_dout_i  : '0;
    assign bus.sram_din_o  = (state_q == RF_WR)   ? bus.sdram_dout_i : '0;
endmodule

// File: doc/line_xfer_ctrl.md
LINE_XFER_CTRL -- requirements
Module: line_xfer_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, SDRAM read latency in cycles from strobe to valid data; legal range 1..7.
REQ-002 SHALL have parameter TAG_W, default 8, tag width; index width is fixed at 3 and offset width at 5, giving a 16-bit SDRAM address.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 op  input  2  01 writeback, 10 refill, 11 writeback then refill, 00 no-op.
REQ-007 blk  input  3  cache block index (SRAM address bits [7:5]).
REQ-008 old_tag / new_tag  input  TAG_W each  SDRAM tag for writeback / refill.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sram_own  output  1  equals busy; selects this block onto the SRAM port.
REQ-012 sram_addr  output  8  {blk, off}.
REQ-013 sram_din  output  8  write data to SRAM; sram_dout  input  8  SRAM read data, valid the cycle after sram_addr is presented.
REQ-014 sram_wen  output  1  SRAM write enable.
REQ-015 sdram_addr  output  16  {tag, blk, off}; sdram_wr_rd  output  1  1 write, 0 read; sdram_mstrb  output  1  one-cycle strobe per byte.
REQ-016 sdram_din  output  8  write data to SDRAM; sdram_dout  input  8  read data from SDRAM.
REQ-017 current_state  output  3  state encoding, for debug probing.

Function
REQ-018 States and encodings: IDLE=0, WB_SRAM=1, WB_STRB=2, RF_STRB=3, RF_WAIT=4, RF_WR=5, DONE=6.
REQ-019 In IDLE with start=1, the block SHALL latch op, blk, old_tag and new_tag, clear off to 0, and go to WB_SRAM if op[0]=1, else RF_STRB if op[1]=1, else DONE.
REQ-020 While busy, start SHALL be ignored and latched inputs SHALL NOT change.
REQ-021 WB_SRAM: sram_addr={blk,off}, sram_wen=0; next state WB_STRB.
REQ-022 WB_STRB: sdram_mstrb=1, sdram_wr_rd=1, sdram_addr={old_tag,blk,off}, sdram_din=sram_dout.
REQ-023 From WB_STRB with off<31: off increments and the next state is WB_SRAM.
REQ-024 From WB_STRB with off=31: off wraps to 0; the next state is RF_STRB if op[1]=1, else DONE.
REQ-025 Writeback SHALL take exactly 64 cycles (2 per byte).
REQ-026 RF_STRB: sdram_mstrb=1, sdram_wr_rd=0, sdram_addr={new_tag,blk,off}.
REQ-027 From RF_STRB: next state is RF_WAIT for RD_LAT-1 cycles, then RF_WR; if RD_LAT=1, next state is RF_WR directly.
REQ-028 RF_WR: sram_addr={blk,off}, sram_din=sdram_dout, sram_wen=1.
REQ-029 From RF_WR: off increments and the next state is RF_STRB, except at off=31, where off wraps to 0 and the next state is DONE.
REQ-030 Refill SHALL take exactly 32*(RD_LAT+1) cycles.
REQ-031 DONE: done=1 for one cycle; next state IDLE. A start presented in DONE SHALL be ignored.
REQ-032 Outside the states named above: sdram_mstrb=0, sram_wen=0, address and data outputs 0, sdram_wr_rd=0.
REQ-033 Exactly one sdram_mstrb pulse SHALL occur per byte; sdram_mstrb and sram_wen SHALL never be high in the same cycle.

Reset
REQ-034 rst=1 at any clock edge SHALL force IDLE, off=0, latched registers to 0, and all outputs to 0, including current_state=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no done pulse; the next start SHALL behave as from power-up.

Verification
REQ-036 op=01, blk=3, old_tag=0x5A, SRAM preloaded 0x60..0x7F=i -> 32 strobes with addr 0x5A60..0x5A7F, data 0..31, wr_rd=1; done 65 cycles after start.
REQ-037 op=10, new_tag=0x12, blk=0, RD_LAT=2, SDRAM model returns addr[7:0]^0xFF -> SRAM 0x00..0x1F written 0xFF..0xE0; done 97 cycles after start.
REQ-038 op=11, RD_LAT=2 -> all 32 write strobes precede the first read strobe; busy spans 161 cycles; exactly one done pulse.
REQ-039 op=00 -> DONE state is entered on the cycle after start; done pulses; no mstrb and no wen pulses occur.
REQ-040 start re-pulsed while busy, and rst asserted at byte 10 of a refill -> re-pulse ignored; after reset, outputs are 0 and state is IDLE with no done pulse; a fresh op=10 completes normally.
REQ-041 RD_LAT=1 and RD_LAT=7 builds -> refill takes 64 and 256 cycles respectively, and RF_WAIT is never entered when RD_LAT=1.
